// File: rtl/eae_sequencer_pkg.sv
// Shared types and constants for the EAE MUY/DVI sequencer.
// Optional divide datapath is selected with the EAE_DVI_EN macro.
package eae_sequencer_pkg;

  localparam int EAE_W    = 12;
  localparam int EAE_ITER = 12;

  localparam logic [3:0] EAE_LAST_STEP = 4'(EAE_ITER - 1);

  typedef enum logic {
    EAE_MUL = 1'b0,
    EAE_DVI = 1'b1
  } eae_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } eae_state_t;

  // A dividend high word not below the divisor cannot yield a 12-bit quotient.
  function automatic logic dvi_overflow(input logic [EAE_W-1:0] ac,
                                        input logic [EAE_W-1:0] divisor);
    return ac >= divisor;
  endfunction

endpackage

// File: rtl/eae_step.sv
// One combinational iteration of the EAE loop: shift-add for MUL and,
// when EAE_DVI_EN is defined, restoring shift-subtract for DVI.
module eae_step
  import eae_sequencer_pkg::*;
(
  input  eae_op_t          op_i,
  input  logic [EAE_W:0]   a_i,
  input  logic [EAE_W-1:0] m_i,
  input  logic [EAE_W-1:0] operand_i,
  output logic [EAE_W:0]   a_o,
  output logic [EAE_W-1:0] m_o
);

  logic [EAE_W:0]   mul_sum;
  logic [EAE_W:0]   mul_a;
  logic [EAE_W-1:0] mul_m;

  always_comb begin
    mul_sum = m_i[0] ? (a_i + {1'b0, operand_i}) : a_i;
    mul_a   = {1'b0, mul_sum[EAE_W:1]};
    mul_m   = {mul_sum[0], m_i[EAE_W-1:1]};
  end

`ifdef EAE_DVI_EN
  logic [EAE_W:0] div_shift;
  logic [EAE_W:0] div_diff;
  logic           div_ge;

  // Partial remainder stays below the divisor, so the shifted value fits 13 bits.
  always_comb begin
    div_shift = {a_i[EAE_W-1:0], m_i[EAE_W-1]};
    div_ge    = div_shift >= {1'b0, operand_i};
    div_diff  = div_shift - {1'b0, operand_i};
  end

  always_comb begin
    if (op_i == EAE_DVI) begin
      a_o = div_ge ? div_diff : div_shift;
      m_o = {m_i[EAE_W-2:0], div_ge};
    end else begin
      a_o = mul_a;
      m_o = mul_m;
    end
  end
`else
  // Without the divider a DVI never iterates; hold state if ever asked.
  always_comb begin
    if (op_i == EAE_DVI) begin
      a_o = a_i;
      m_o = m_i;
    end else begin
      a_o = mul_a;
      m_o = mul_m;
    end
  end
`endif

endmodule

// File: rtl/eae_sequencer.sv
// EAE MUY/DVI multi-cycle sequencer: IDLE -> LOAD -> ITER x12 -> DONE.
// Define EAE_DVI_EN to build the divider; otherwise every DVI reports overflow.
module eae_sequencer
  import eae_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  eae_op_t          op,
  input  logic [EAE_W-1:0] ac_in,
  input  logic [EAE_W-1:0] mq_in,
  input  logic [EAE_W-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [EAE_W-1:0] ac_mul,
  output logic [EAE_W-1:0] mq_mul,
  output logic [EAE_W-1:0] ac_dvi,
  output logic [EAE_W-1:0] mq_dvi,
  output logic             link_dvi
);

  eae_state_t       state_q, state_d;
  logic [3:0]       step_q, step_d;
  eae_op_t          op_q, op_d;
  logic [EAE_W:0]   a_q, a_d;
  logic [EAE_W-1:0] m_q, m_d;
  logic [EAE_W-1:0] opd_q, opd_d;
  logic [EAE_W-1:0] ac_mul_q, ac_mul_d;
  logic [EAE_W-1:0] mq_mul_q, mq_mul_d;
  logic [EAE_W-1:0] ac_dvi_q, ac_dvi_d;
  logic [EAE_W-1:0] mq_dvi_q, mq_dvi_d;
  logic             link_dvi_q, link_dvi_d;

  logic [EAE_W:0]   step_a;
  logic [EAE_W-1:0] step_m;
  logic             dvi_ovf;

  eae_step u_step (
    .op_i      (op_q),
    .a_i       (a_q),
    .m_i       (m_q),
    .operand_i (opd_q),
    .a_o       (step_a),
    .m_o       (step_m)
  );

`ifdef EAE_DVI_EN
  assign dvi_ovf = (op_q == EAE_DVI) && dvi_overflow(a_q[EAE_W-1:0], opd_q);
`else
  assign dvi_ovf = (op_q == EAE_DVI);
`endif

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    op_d       = op_q;
    a_d        = a_q;
    m_d        = m_q;
    opd_d      = opd_q;
    ac_mul_d   = ac_mul_q;
    mq_mul_d   = mq_mul_q;
    ac_dvi_d   = ac_dvi_q;
    mq_dvi_d   = mq_dvi_q;
    link_dvi_d = link_dvi_q;

    case (state_q)
      IDLE: begin
        step_d = 4'd0;
        if (start) begin
          op_d    = op;
          a_d     = {1'b0, ac_in};
          m_d     = mq_in;
          opd_d   = operand;
          state_d = LOAD;
        end
      end
      LOAD: begin
        step_d = 4'd0;
        if (dvi_ovf) begin
          ac_dvi_d   = a_q[EAE_W-1:0];
          mq_dvi_d   = m_q;
          link_dvi_d = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        a_d    = step_a;
        m_d    = step_m;
        step_d = step_q + 4'd1;
        if (step_q == EAE_LAST_STEP) begin
          step_d  = 4'd0;
          state_d = DONE;
`ifdef EAE_DVI_EN
          if (op_q == EAE_DVI) begin
            ac_dvi_d   = step_a[EAE_W-1:0];
            mq_dvi_d   = step_m;
            link_dvi_d = 1'b0;
          end else begin
            ac_mul_d = step_a[EAE_W-1:0];
            mq_mul_d = step_m;
          end
`else
          ac_mul_d = step_a[EAE_W-1:0];
          mq_mul_d = step_m;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= 4'd0;
      op_q       <= EAE_MUL;
      a_q        <= '0;
      m_q        <= '0;
      opd_q      <= '0;
      ac_mul_q   <= '0;
      mq_mul_q   <= '0;
      ac_dvi_q   <= '0;
      mq_dvi_q   <= '0;
      link_dvi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      op_q       <= op_d;
      a_q        <= a_d;
      m_q        <= m_d;
      opd_q      <= opd_d;
      ac_mul_q   <= ac_mul_d;
      mq_mul_q   <= mq_mul_d;
      ac_dvi_q   <= ac_dvi_d;
      mq_dvi_q   <= mq_dvi_d;
      link_dvi_q <= link_dvi_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign ac_mul   = ac_mul_q;
  assign mq_mul   = mq_mul_q;
  assign ac_dvi   = ac_dvi_q;
  assign mq_dvi   = mq_dvi_q;
  assign link_dvi = link_dvi_q;

endmodule

// File: tb/tb_eae_sequencer.sv
// Directed scoreboard bench for eae_sequencer; expectations follow EAE_DVI_EN.
module tb_eae_sequencer;
  import eae_sequencer_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  eae_op_t     op;
  logic [11:0] ac_in, mq_in, operand;
  logic        busy, done;
  logic [11:0] ac_mul, mq_mul, ac_dvi, mq_dvi;
  logic        link_dvi;

  eae_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .ac_in    (ac_in),
    .mq_in    (mq_in),
    .operand  (operand),
    .busy     (busy),
    .done     (done),
    .ac_mul   (ac_mul),
    .mq_mul   (mq_mul),
    .ac_dvi   (ac_dvi),
    .mq_dvi   (mq_dvi),
    .link_dvi (link_dvi)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        is_dvi;
    logic [11:0] ac;
    logic [11:0] mq;
    logic        link;
    int          lat;
  } exp_t;

  exp_t sb[$];

  logic [11:0] m_ac_mul, m_mq_mul, m_ac_dvi, m_mq_dvi;
  logic        m_link;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic exp_t model(input eae_op_t o, input logic [11:0] a,
                                 input logic [11:0] q, input logic [11:0] d);
    exp_t        e;
    logic [23:0] full;
    e.is_dvi = (o == EAE_DVI);
    if (o == EAE_MUL) begin
      full   = 24'(q) * 24'(d) + 24'(a);
      e.ac   = full[23:12];
      e.mq   = full[11:0];
      e.link = 1'b0;
      e.lat  = 14;
    end else begin
`ifdef EAE_DVI_EN
      if (a < d) begin
        full   = {a, q};
        e.mq   = 12'(full / 24'(d));
        e.ac   = 12'(full % 24'(d));
        e.link = 1'b0;
        e.lat  = 14;
      end else
`endif
      begin
        e.ac   = a;
        e.mq   = q;
        e.link = 1'b1;
        e.lat  = 2;
      end
    end
    return e;
  endfunction

  // Starts one operation in the current (idle) cycle and follows it cycle by cycle.
  // inj: cycle in which a stray start is driven; rst_at: cycle in which reset hits.
  task automatic run_op(input eae_op_t o, input logic [11:0] a, input logic [11:0] q,
                        input logic [11:0] d, input int inj, input int rst_at);
    exp_t e;
    exp_t got;
    bit   seen;
    int   done_k;
    e = model(o, a, q, d);
    op      = o;
    ac_in   = a;
    mq_in   = q;
    operand = d;
    start   = 1'b1;
    sb.push_back(e);
    seen   = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      start   = 1'b0;
      op      = eae_op_t'($urandom_range(0, 1));
      ac_in   = 12'($urandom);
      mq_in   = 12'($urandom);
      operand = 12'($urandom);
      if (k == inj) start = 1'b1;
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ac_mul", {20'd0, ac_mul}, 0);
        chk("rst_mq_mul", {20'd0, mq_mul}, 0);
        chk("rst_link", {31'd0, link_dvi}, 0);
        sb.delete();
        m_ac_mul = '0; m_mq_mul = '0; m_ac_dvi = '0; m_mq_dvi = '0; m_link = 1'b0;
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clock);
          chk("post_rst_done", {31'd0, done}, 0);
          chk("post_rst_busy", {31'd0, busy}, 0);
        end
        $display("op=%s ac=%o mq=%o opd=%o aborted by reset at cycle %0d",
                 o.name(), a, q, d, k);
        return;
      end
      chk("busy", {31'd0, busy}, {31'd0, (k <= e.lat)});
      chk("done", {31'd0, done}, {31'd0, (k == e.lat)});
      if (done) begin
        seen   = 1'b1;
        done_k = k;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          got = sb.pop_front();
          if (got.is_dvi) begin
            m_ac_dvi = got.ac; m_mq_dvi = got.mq; m_link = got.link;
          end else begin
            m_ac_mul = got.ac; m_mq_mul = got.mq;
          end
          chk("ac_mul", {20'd0, ac_mul}, {20'd0, m_ac_mul});
          chk("mq_mul", {20'd0, mq_mul}, {20'd0, m_mq_mul});
          chk("ac_dvi", {20'd0, ac_dvi}, {20'd0, m_ac_dvi});
          chk("mq_dvi", {20'd0, mq_dvi}, {20'd0, m_mq_dvi});
          chk("link_dvi", {31'd0, link_dvi}, {31'd0, m_link});
        end
      end
      if (k == e.lat + 1) break;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 1);
    $display("op=%s ac=%o mq=%o opd=%o done_cycle=%0d ac_mul=%o mq_mul=%o ac_dvi=%o mq_dvi=%o link=%0b",
             o.name(), a, q, d, done_k, ac_mul, mq_mul, ac_dvi, mq_dvi, link_dvi);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = EAE_MUL;
    ac_in   = '0;
    mq_in   = '0;
    operand = '0;
    m_ac_mul = '0; m_mq_mul = '0; m_ac_dvi = '0; m_mq_dvi = '0; m_link = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_ac_mul", {20'd0, ac_mul}, 0);
    chk("reset_mq_mul", {20'd0, mq_mul}, 0);
    chk("reset_ac_dvi", {20'd0, ac_dvi}, 0);
    chk("reset_mq_dvi", {20'd0, mq_dvi}, 0);
    chk("reset_link", {31'd0, link_dvi}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_op(EAE_MUL, 12'o0000, 12'o0003, 12'o0005, 0, 0);
    chk("plan_mul_ac", {20'd0, ac_mul}, 32'o0000);
    chk("plan_mul_mq", {20'd0, mq_mul}, 32'o0017);

    run_op(EAE_MUL, 12'o7777, 12'o7777, 12'o7777, 0, 0);
    chk("plan_max_ac", {20'd0, ac_mul}, 32'o7777);
    chk("plan_max_mq", {20'd0, mq_mul}, 32'o0000);

    run_op(EAE_DVI, 12'o0000, 12'o0144, 12'o0007, 0, 0);
`ifdef EAE_DVI_EN
    chk("plan_dvi_mq", {20'd0, mq_dvi}, 32'o0016);
    chk("plan_dvi_ac", {20'd0, ac_dvi}, 32'o0002);
    chk("plan_dvi_link", {31'd0, link_dvi}, 0);
`else
    chk("plan_nodvi_link", {31'd0, link_dvi}, 1);
    chk("plan_nodvi_mq", {20'd0, mq_dvi}, 32'o0144);
`endif

    run_op(EAE_DVI, 12'o0005, 12'o0123, 12'o0005, 0, 0);
    chk("plan_ovf_link", {31'd0, link_dvi}, 1);
    chk("plan_ovf_ac", {20'd0, ac_dvi}, 32'o0005);
    chk("plan_ovf_mq", {20'd0, mq_dvi}, 32'o0123);

    run_op(EAE_DVI, 12'o0005, 12'o0456, 12'o0000, 0, 0);
    chk("plan_dz_link", {31'd0, link_dvi}, 1);
    chk("plan_dz_mq", {20'd0, mq_dvi}, 32'o0456);

    run_op(EAE_MUL, 12'o0012, 12'o0034, 12'o0056, 5, 0);
    run_op(EAE_MUL, 12'o0001, 12'o0002, 12'o0003, 14, 0);
    run_op(EAE_MUL, 12'o0100, 12'o0200, 12'o0300, 0, 8);
    run_op(EAE_MUL, 12'o0004, 12'o0006, 12'o0010, 0, 0);

    for (int i = 0; i < 6; i++) begin
      logic [11:0] ra, rq, rd;
      rd = 12'($urandom_range(1, 4095));
      ra = 12'($urandom_range(0, 4095));
      rq = 12'($urandom);
      if (i % 2 == 1 && ra >= rd) ra = 12'(ra % rd);
      run_op((i % 2 == 1) ? EAE_DVI : EAE_MUL, ra, rq, rd, 0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
